// File: rtl/water_level_driver.sv
// water_level_driver: steps the chamber level one unit every STEP_DIV cycles toward a clamped
// target, then pulses done for one cycle.
module water_level_driver #(
    parameter int WIDTH      = 8,
    parameter int STEP_DIV   = 4,
    parameter int MAX_LEVEL  = 100,
    parameter int MIN_LEVEL  = 0,
    parameter int INIT_LEVEL = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] target,
    output logic [WIDTH-1:0] level,
    output logic             filling,
    output logic             draining,
    output logic             busy,
    output logic             done
);
    localparam int PW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(STEP_DIV - 1);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FILL  = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] level_q, level_d;
    logic [WIDTH-1:0] tgt_q, tgt_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic [WIDTH-1:0] clamped;
    logic             moving;
    logic             step;
    int               tgt_i;

    always_comb begin
        state_d = state_q;
        level_d = level_q;
        tgt_d   = tgt_q;
        presc_d = presc_q;
        // signed int compare keeps the lower clamp meaningful for any MIN_LEVEL
        tgt_i   = int'(target);
        clamped = (tgt_i > MAX_LEVEL) ? WIDTH'(MAX_LEVEL) :
                  (tgt_i < MIN_LEVEL) ? WIDTH'(MIN_LEVEL) : target;
        moving  = (state_q == FILL) || (state_q == DRAIN);
        step    = (presc_q == LAST);
        if (state_q == IDLE && start) begin
            tgt_d   = clamped;
            presc_d = '0;
            state_d = (clamped > level_q) ? FILL : (clamped < level_q) ? DRAIN : DONE;
        end else if (moving && abort) begin
            state_d = IDLE;
            presc_d = '0;
        end else if (moving) begin
            presc_d = step ? '0 : presc_q + PW'(1);
            if (step) begin
                level_d = (state_q == FILL) ? level_q + WIDTH'(1) : level_q - WIDTH'(1);
                state_d = (level_d == tgt_q) ? DONE : state_q;
            end
        end else if (state_q == DONE) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            level_q <= WIDTH'(INIT_LEVEL);
            tgt_q   <= WIDTH'(INIT_LEVEL);
            presc_q <= '0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            tgt_q   <= tgt_d;
            presc_q <= presc_d;
        end
    end

    assign level    = level_q;
    assign filling  = (state_q == FILL);
    assign draining = (state_q == DRAIN);
    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);
endmodule

// File: tb/tb_water_level_driver.sv
// tb_water_level_driver: table-driven and randomized moves checked against an arithmetic level model.
module tb_water_level_driver;
    localparam int S = 4;
    localparam int MAXL = 100;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] target = '0;
    logic [7:0] level;
    logic       filling, draining, busy, done;
    int         tests = 0;
    int         fails = 0;
    int         lvl_m = 0;

    water_level_driver dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .target(target),
        .level(level), .filling(filling), .draining(draining), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] tgt;
        int         ab;
        bit         noise;
        int         exp_level;
        int         exp_cycles;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
        end
    endtask

    // Model: each STEP_DIV cycles the level moves one unit toward the clamped target;
    // an abort sampled at cycle ab suppresses any step on that same edge.
    task automatic do_move(input logic [7:0] tgt, input int ab, input bit noise,
                           output int cyc, output int fin);
        int tc, d, sg, n, ne, exp_l, fin_m, bad;
        bit mv, dn;
        tc    = (int'(tgt) > MAXL) ? MAXL : int'(tgt);
        d     = (tc > lvl_m) ? tc - lvl_m : lvl_m - tc;
        sg    = (tc > lvl_m) ? 1 : (tc < lvl_m) ? -1 : 0;
        fin_m = (ab != 0) ? lvl_m + sg * ((ab - 1) / S) : tc;
        bad   = 0;
        n     = 0;
        start = 1'b1;
        target = tgt;
        tick();
        start = 1'b0;
        forever begin
            ne    = (ab != 0 && n >= ab) ? ab - 1 : n;
            exp_l = lvl_m + sg * (((ne / S) < d) ? ne / S : d);
            mv    = (d > 0) && (n < d * S) && !(ab != 0 && n >= ab);
            dn    = (ab == 0) && (n == d * S);
            if (int'(level) != exp_l) bad++;
            if (filling != (mv && sg > 0)) bad++;
            if (draining != (mv && sg < 0)) bad++;
            if (done != dn) bad++;
            if (busy != (mv || dn)) bad++;
            if ((ab != 0 && n == ab) || done || n > d * S + 20) break;
            if (noise) begin
                start  = 1'b1;
                target = 8'($urandom);
            end
            abort = (ab != 0 && n == ab - 1);
            tick();
            abort = 1'b0;
            n++;
        end
        cyc = n;
        check("trajectory", bad, 0);
        check("move_cycles", n, (ab != 0) ? ab : d * S);
        start = noise && (ab == 0);
        tick();
        start = 1'b0;
        check("post_idle", {30'd0, busy, done}, 0);
        check("post_level", int'(level), fin_m);
        fin = int'(level);
        lvl_m = fin_m;
    endtask

    initial begin
        vec_t vecs[13];
        int cyc, fin, tg, ab, d, tc;
        bit nz;
        vecs = '{
            '{8'd3,   0,  1'b0, 3,   12},
            '{8'd50,  0,  1'b0, 50,  188},
            '{8'd45,  0,  1'b0, 45,  20},
            '{8'd200, 0,  1'b0, 100, 220},
            '{8'd255, 0,  1'b0, 100, 0},
            '{8'd50,  0,  1'b0, 50,  200},
            '{8'd50,  0,  1'b0, 50,  0},
            '{8'd0,   0,  1'b0, 0,   200},
            '{8'd5,   8,  1'b0, 1,   8},
            '{8'd5,   0,  1'b0, 5,   16},
            '{8'd8,   0,  1'b1, 8,   12},
            '{8'd2,   24, 1'b0, 3,   24},
            '{8'd0,   1,  1'b0, 3,   1}
        };
        repeat (2) tick();
        check("reset_level", int'(level), 0);
        check("reset_flags", {28'd0, filling, draining, busy, done}, 0);
        reset = 1'b1;
        tick();
        // asynchronous reset in the middle of a fill
        start = 1'b1;
        target = 8'd10;
        tick();
        start = 1'b0;
        repeat (5) tick();
        check("pre_reset_level", int'(level), 1);
        #2 reset = 1'b0;
        #1;
        check("async_reset_level", int'(level), 0);
        check("async_reset_flags", {29'd0, busy, done, filling}, 0);
        repeat (2) tick();
        reset = 1'b1;
        repeat (3) tick();
        check("after_release_level", int'(level), 0);
        check("after_release_busy", {31'd0, busy}, 0);
        lvl_m = 0;
        foreach (vecs[i]) begin
            do_move(vecs[i].tgt, vecs[i].ab, vecs[i].noise, cyc, fin);
            check($sformatf("vec%0d_level", i), fin, vecs[i].exp_level);
            check($sformatf("vec%0d_cycles", i), cyc, vecs[i].exp_cycles);
        end
        for (int k = 0; k < 16; k++) begin
            tg = $urandom_range(0, 255);
            tc = (tg > MAXL) ? MAXL : tg;
            d  = (tc > lvl_m) ? tc - lvl_m : lvl_m - tc;
            ab = (d > 0 && $urandom_range(0, 3) == 0) ? $urandom_range(1, d * S) : 0;
            nz = (ab == 0) && ($urandom_range(0, 1) == 1);
            do_move(8'(tg), ab, nz, cyc, fin);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
